// File: rtl/wta_winner_decoder_if.sv
// Single-entry event port of the WTA winner decoder: valid/ready with winner and magnitude payload.
interface wta_winner_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_winner;
  logic [3:0] evt_mag;

  modport master (output evt_valid, output evt_winner, output evt_mag, input evt_ready);
  modport slave  (input evt_valid, input evt_winner, input evt_mag, output evt_ready);
endinterface

// File: rtl/wta_winner_decoder.sv
// Receive side of the winner-take-all stage: classifies samples, debounces winner changes,
// emits one event per confirmed change and keeps saturating win counters plus sticky errors.
module wta_winner_decoder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           wta_in,
  input  logic                 clr,
  output logic                 cur_valid,
  output logic                 cur_winner,
  output logic [3:0]           cur_mag,
  wta_winner_decoder_if.master evt,
  output logic [CNT_W-1:0]     win_hi_cnt,
  output logic [CNT_W-1:0]     win_lo_cnt,
  output logic                 err_bad,
  output logic                 err_ovf
);

  typedef enum logic {IDLE, CONFIRMED} state_t;

  state_t state_q, state_d;

  logic             cand_q, cand_d;
  logic [3:0]       cand_cnt_q, cand_cnt_d;
  logic             cur_winner_q, cur_winner_d;
  logic [3:0]       cur_mag_q, cur_mag_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_winner_q, evt_winner_d;
  logic [3:0]       evt_mag_q, evt_mag_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic             err_bad_q, err_bad_d;
  logic             err_ovf_q, err_ovf_d;

  logic       hi_nz, lo_nz, is_hi, is_bad;
  logic       take, bad_s, match_cur, confirm;
  logic [3:0] mag, run_cnt;

  // Sample classification; is_hi doubles as the class bit (1=HI, 0=LO).
  always_comb begin
    hi_nz     = |wta_in[7:4];
    lo_nz     = |wta_in[3:0];
    is_hi     = hi_nz & ~lo_nz;
    is_bad    = hi_nz & lo_nz;
    take      = in_valid & (hi_nz ^ lo_nz);
    bad_s     = in_valid & is_bad;
    mag       = is_hi ? wta_in[7:4] : wta_in[3:0];
    match_cur = (state_q == CONFIRMED) && (is_hi == cur_winner_q);
    run_cnt   = ((cand_cnt_q != '0) && (is_hi == cand_q)) ? cand_cnt_q + 4'd1 : 4'd1;
    confirm   = take & ~match_cur & (run_cnt == 4'(HOLD_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (confirm) state_d = CONFIRMED;
  end

  always_comb begin
    cur_valid = (state_q == CONFIRMED);
  end

  always_comb begin
    cand_d       = cand_q;
    cand_cnt_d   = cand_cnt_q;
    cur_winner_d = cur_winner_q;
    cur_mag_d    = cur_mag_q;
    evt_valid_d  = evt_valid_q;
    evt_winner_d = evt_winner_q;
    evt_mag_d    = evt_mag_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    err_bad_d    = err_bad_q;
    err_ovf_d    = err_ovf_q;

    if (bad_s) begin
      err_bad_d  = 1'b1;
      cand_cnt_d = '0;
    end else if (take) begin
      if (match_cur) begin
        cand_cnt_d = '0;
        cur_mag_d  = mag;
      end else if (confirm) begin
        cand_d       = is_hi;
        cand_cnt_d   = '0;
        cur_winner_d = is_hi;
        cur_mag_d    = mag;
      end else begin
        cand_d     = is_hi;
        cand_cnt_d = run_cnt;
      end
      if (is_hi && hi_cnt_q != '1) hi_cnt_d = hi_cnt_q + 1'b1;
      if (!is_hi && lo_cnt_q != '1) lo_cnt_d = lo_cnt_q + 1'b1;
    end

    // A load on the handshake edge replaces the retiring entry instead of clearing it.
    if (confirm) begin
      if (evt_valid_q && !evt.evt_ready) err_ovf_d = 1'b1;
      evt_valid_d  = 1'b1;
      evt_winner_d = is_hi;
      evt_mag_d    = mag;
    end else if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (clr) begin
      hi_cnt_d  = '0;
      lo_cnt_d  = '0;
      err_bad_d = 1'b0;
      err_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q       <= 1'b0;
      cand_cnt_q   <= '0;
      cur_winner_q <= 1'b0;
      cur_mag_q    <= '0;
      evt_valid_q  <= 1'b0;
      evt_winner_q <= 1'b0;
      evt_mag_q    <= '0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      err_bad_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cand_cnt_q   <= cand_cnt_d;
      cur_winner_q <= cur_winner_d;
      cur_mag_q    <= cur_mag_d;
      evt_valid_q  <= evt_valid_d;
      evt_winner_q <= evt_winner_d;
      evt_mag_q    <= evt_mag_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      err_bad_q    <= err_bad_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  always_comb begin
    cur_winner     = cur_winner_q;
    cur_mag        = cur_mag_q;
    evt.evt_valid  = evt_valid_q;
    evt.evt_winner = evt_winner_q;
    evt.evt_mag    = evt_mag_q;
    win_hi_cnt     = hi_cnt_q;
    win_lo_cnt     = lo_cnt_q;
    err_bad        = err_bad_q;
    err_ovf        = err_ovf_q;
  end

endmodule

// File: tb/tb_wta_winner_decoder.sv
// Bench for wta_winner_decoder: directed vector table, hand-written reset/saturation sequences
// and randomized traffic, all checked against a behavioural model (two parameterisations).
module tb_wta_winner_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] wta_in;
  logic       clr;
  logic       rdy;

  always #5 clk = ~clk;

  typedef struct {
    int cv, cw, cm, ev, ew, em, hi, lo, bad, ovf;
  } obs_t;

  typedef struct {
    obs_t o;
    int   run_cls;
    int   run_len;
  } mdl_t;

  typedef struct {
    logic       v;
    logic [7:0] w;
    logic       c;
    logic       r;
    obs_t       e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // DUT A: HOLD_CYCLES=4, CNT_W=8
  wta_winner_decoder_if evt_a ();
  logic       a_cv, a_cw;
  logic [3:0] a_cm;
  logic [7:0] a_hi, a_lo;
  logic       a_bad, a_ovf;
  assign evt_a.evt_ready = rdy;

  wta_winner_decoder #(.HOLD_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wta_in(wta_in), .clr(clr),
    .cur_valid(a_cv), .cur_winner(a_cw), .cur_mag(a_cm), .evt(evt_a.master),
    .win_hi_cnt(a_hi), .win_lo_cnt(a_lo), .err_bad(a_bad), .err_ovf(a_ovf)
  );

  // DUT B: HOLD_CYCLES=1, CNT_W=2
  wta_winner_decoder_if evt_b ();
  logic       b_cv, b_cw;
  logic [3:0] b_cm;
  logic [1:0] b_hi, b_lo;
  logic       b_bad, b_ovf;
  assign evt_b.evt_ready = rdy;

  wta_winner_decoder #(.HOLD_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wta_in(wta_in), .clr(clr),
    .cur_valid(b_cv), .cur_winner(b_cw), .cur_mag(b_cm), .evt(evt_b.master),
    .win_hi_cnt(b_hi), .win_lo_cnt(b_lo), .err_bad(b_bad), .err_ovf(b_ovf)
  );

  mdl_t ma, mb;

  function automatic obs_t obs_a();
    obs_t o;
    o.cv = int'(a_cv); o.cw = int'(a_cw); o.cm = int'(a_cm);
    o.ev = int'(evt_a.evt_valid); o.ew = int'(evt_a.evt_winner); o.em = int'(evt_a.evt_mag);
    o.hi = int'(a_hi); o.lo = int'(a_lo); o.bad = int'(a_bad); o.ovf = int'(a_ovf);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.cv = int'(b_cv); o.cw = int'(b_cw); o.cm = int'(b_cm);
    o.ev = int'(evt_b.evt_valid); o.ew = int'(evt_b.evt_winner); o.em = int'(evt_b.evt_mag);
    o.hi = int'(b_hi); o.lo = int'(b_lo); o.bad = int'(b_bad); o.ovf = int'(b_ovf);
    return o;
  endfunction

  function automatic obs_t mko(int cv, int cw, int cm, int ev, int ew, int em,
                               int hi, int lo, int bad, int ovf);
    obs_t o;
    o.cv = cv; o.cw = cw; o.cm = cm; o.ev = ev; o.ew = ew; o.em = em;
    o.hi = hi; o.lo = lo; o.bad = bad; o.ovf = ovf;
    return o;
  endfunction

  function automatic vec_t mk(logic v, logic [7:0] w, logic c, logic r, obs_t e);
    vec_t t;
    t.v = v; t.w = w; t.c = c; t.r = r; t.e = e;
    return t;
  endfunction

  // Reference: one clock edge of the decoder, from the behavioural rules.
  function automatic mdl_t mstep(mdl_t m, logic rn, logic v, logic [7:0] w, logic c, logic r,
                                 int hold, int maxc);
    int hn, ln, cls, mg;
    bit load;
    mdl_t z;
    if (!rn) begin
      z.o = mko(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      z.run_cls = 0;
      z.run_len = 0;
      return z;
    end
    hn = int'(w[7:4]);
    ln = int'(w[3:0]);
    load = 0;
    mg = 0;
    if (v) begin
      if (hn != 0 && ln != 0) begin
        m.o.bad = 1;
        m.run_len = 0;
      end else if (hn != 0 || ln != 0) begin
        cls = (hn != 0) ? 1 : 0;
        mg  = (cls == 1) ? hn : ln;
        if (cls == 1) m.o.hi = (m.o.hi + 1 > maxc) ? maxc : m.o.hi + 1;
        else          m.o.lo = (m.o.lo + 1 > maxc) ? maxc : m.o.lo + 1;
        if (m.o.cv == 1 && cls == m.o.cw) begin
          m.run_len = 0;
          m.o.cm = mg;
        end else begin
          if (m.run_len > 0 && cls == m.run_cls) m.run_len++;
          else begin
            m.run_cls = cls;
            m.run_len = 1;
          end
          if (m.run_len == hold) begin
            m.o.cv = 1; m.o.cw = cls; m.o.cm = mg; m.run_len = 0; load = 1;
          end
        end
      end
    end
    if (load) begin
      if (m.o.ev == 1 && !r) m.o.ovf = 1;
      m.o.ev = 1; m.o.ew = m.o.cw; m.o.em = mg;
    end else if (m.o.ev == 1 && r) begin
      m.o.ev = 0;
    end
    if (c) begin
      m.o.hi = 0; m.o.lo = 0; m.o.bad = 0; m.o.ovf = 0;
    end
    return m;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic cmp(input string p, input obs_t a, input obs_t e);
    chk({p, ".cur_valid"},  a.cv,  e.cv);
    chk({p, ".cur_winner"}, a.cw,  e.cw);
    chk({p, ".cur_mag"},    a.cm,  e.cm);
    chk({p, ".evt_valid"},  a.ev,  e.ev);
    chk({p, ".evt_winner"}, a.ew,  e.ew);
    chk({p, ".evt_mag"},    a.em,  e.em);
    chk({p, ".win_hi_cnt"}, a.hi,  e.hi);
    chk({p, ".win_lo_cnt"}, a.lo,  e.lo);
    chk({p, ".err_bad"},    a.bad, e.bad);
    chk({p, ".err_ovf"},    a.ovf, e.ovf);
  endtask

  task automatic step(input logic rn, input logic v, input logic [7:0] w,
                      input logic c, input logic r);
    rst_n = rn; in_valid = v; wta_in = w; clr = c; rdy = r;
    @(posedge clk);
    ma = mstep(ma, rn, v, w, c, r, 4, 255);
    mb = mstep(mb, rn, v, w, c, r, 1, 3);
    #1;
  endtask

  task automatic cmp_models(input string tag);
    cmp({tag, ".A"}, obs_a(), ma.o);
    cmp({tag, ".B"}, obs_b(), mb.o);
  endtask

  vec_t tbl[$];
  logic [3:0] nib;
  int pref;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wta_in = '0; clr = 1'b0; rdy = 1'b0;
    ma = mstep(ma, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4, 255);
    mb = mstep(mb, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 3);

    // Directed table for DUT A (HOLD=4); expected values after each edge.
    tbl.push_back(mk(1, 8'h50, 0, 0, mko(0,0,0, 0,0,0,  1,0,0,0)));
    tbl.push_back(mk(1, 8'h50, 0, 0, mko(0,0,0, 0,0,0,  2,0,0,0)));
    tbl.push_back(mk(1, 8'h50, 0, 0, mko(0,0,0, 0,0,0,  3,0,0,0)));
    tbl.push_back(mk(1, 8'h50, 0, 0, mko(1,1,5, 1,1,5,  4,0,0,0)));
    tbl.push_back(mk(1, 8'h03, 0, 1, mko(1,1,5, 0,1,5,  4,1,0,0)));
    tbl.push_back(mk(1, 8'h03, 0, 0, mko(1,1,5, 0,1,5,  4,2,0,0)));
    tbl.push_back(mk(1, 8'h00, 0, 0, mko(1,1,5, 0,1,5,  4,2,0,0)));
    tbl.push_back(mk(1, 8'h03, 0, 0, mko(1,1,5, 0,1,5,  4,3,0,0)));
    tbl.push_back(mk(1, 8'h03, 0, 0, mko(1,0,3, 1,0,3,  4,4,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,0,3, 1,0,3,  5,4,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,0,3, 1,0,3,  6,4,0,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,0,2, 1,0,3,  6,5,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,0,2, 1,0,3,  7,5,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,0,2, 1,0,3,  8,5,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,0,2, 1,0,3,  9,5,0,0)));
    tbl.push_back(mk(1, 8'h60, 0, 0, mko(1,1,6, 1,1,6, 10,5,0,1)));
    tbl.push_back(mk(1, 8'h35, 0, 0, mko(1,1,6, 1,1,6, 10,5,1,1)));
    tbl.push_back(mk(0, 8'h00, 1, 0, mko(1,1,6, 1,1,6,  0,0,0,0)));
    tbl.push_back(mk(1, 8'h04, 0, 0, mko(1,1,6, 1,1,6,  0,1,0,0)));
    tbl.push_back(mk(1, 8'h04, 0, 0, mko(1,1,6, 1,1,6,  0,2,0,0)));
    tbl.push_back(mk(1, 8'h04, 0, 0, mko(1,1,6, 1,1,6,  0,3,0,0)));
    tbl.push_back(mk(1, 8'h04, 0, 1, mko(1,0,4, 1,0,4,  0,4,0,0)));
    tbl.push_back(mk(0, 8'h00, 0, 1, mko(1,0,4, 0,0,4,  0,4,0,0)));
    tbl.push_back(mk(1, 8'h10, 1, 0, mko(1,0,4, 0,0,4,  0,0,0,0)));
    tbl.push_back(mk(0, 8'h50, 0, 0, mko(1,0,4, 0,0,4,  0,0,0,0)));
    tbl.push_back(mk(1, 8'h10, 0, 0, mko(1,0,4, 0,0,4,  1,0,0,0)));
    tbl.push_back(mk(1, 8'h10, 0, 0, mko(1,0,4, 0,0,4,  2,0,0,0)));
    tbl.push_back(mk(1, 8'h10, 0, 0, mko(1,1,1, 1,1,1,  3,0,0,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,1,1, 1,1,1,  3,1,0,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,1,1, 1,1,1,  3,2,0,0)));
    tbl.push_back(mk(1, 8'h35, 0, 0, mko(1,1,1, 1,1,1,  3,2,1,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,1,1, 1,1,1,  3,3,1,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,1,1, 1,1,1,  3,4,1,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,1,1, 1,1,1,  3,5,1,0)));
    tbl.push_back(mk(1, 8'h02, 0, 0, mko(1,0,2, 1,0,2,  3,6,1,1)));

    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    cmp("reset.A", obs_a(), mko(0,0,0, 0,0,0, 0,0,0,0));
    cmp("reset.B", obs_b(), mko(0,0,0, 0,0,0, 0,0,0,0));

    foreach (tbl[i]) begin
      step(1, tbl[i].v, tbl[i].w, tbl[i].c, tbl[i].r);
      cmp($sformatf("vec%0d.A", i), obs_a(), tbl[i].e);
      cmp($sformatf("vec%0d.Bm", i), obs_b(), mb.o);
    end

    // Reset while busy with active clr and sample: everything returns to zero.
    step(0, 1, 8'h20, 1, 0);
    cmp("rst_busy.A", obs_a(), mko(0,0,0, 0,0,0, 0,0,0,0));
    cmp("rst_busy.B", obs_b(), mko(0,0,0, 0,0,0, 0,0,0,0));

    // HOLD=1 confirms on the first sample; CNT_W=2 saturates at 3.
    step(1, 1, 8'h10, 0, 0);
    cmp("hold1.B", obs_b(), mko(1,1,1, 1,1,1, 1,0,0,0));
    for (int k = 0; k < 5; k++) step(1, 1, 8'h10, 0, 0);
    chk("sat.B.win_hi_cnt", int'(b_hi), 3);
    chk("sat.A.win_hi_cnt", int'(a_hi), 6);
    chk("sat.A.cur_valid", int'(a_cv), 1);
    cmp_models("sat");

    // Reset in the middle of a LO run: the partial run must not survive.
    for (int k = 0; k < 3; k++) step(1, 1, 8'h02, 0, 1);
    step(0, 1, 8'h02, 0, 1);
    cmp("rst_mid.A", obs_a(), mko(0,0,0, 0,0,0, 0,0,0,0));
    for (int k = 0; k < 3; k++) step(1, 1, 8'h02, 0, 1);
    chk("rst_mid.A.cur_valid_after3", int'(a_cv), 0);
    step(1, 1, 8'h02, 0, 1);
    cmp("rst_mid.A.confirm", obs_a(), mko(1,0,2, 1,0,2, 0,4,0,0));
    cmp_models("rst_mid");

    // Randomized traffic with a drifting preferred class so runs confirm regularly.
    pref = 1;
    for (int k = 0; k < 3000; k++) begin
      logic       rv, rc, rr, rn;
      logic [7:0] rw;
      int         sel;
      if ($urandom_range(0, 7) == 0) pref = 1 - pref;
      nib = 4'($urandom_range(1, 15));
      sel = int'($urandom_range(0, 19));
      if (sel < 3)       rw = 8'h00;
      else if (sel < 15) rw = (pref == 1) ? {nib, 4'h0} : {4'h0, nib};
      else if (sel < 18) rw = (pref == 1) ? {4'h0, nib} : {nib, 4'h0};
      else if (sel < 19) rw = {nib, 4'($urandom_range(1, 15))};
      else               rw = 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 9) != 0);
      rc = ($urandom_range(0, 63) == 0);
      rr = ($urandom_range(0, 2) != 0);
      rn = ($urandom_range(0, 499) != 0);
      step(rn, rv, rw, rc, rr);
      cmp_models($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
